// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard-controller states, register-file
// constants and the NOP encoding loaded by flushed stage registers.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } hz_state_e;

    localparam int              REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls,
// taken-branch flushes, data-memory freezes, plus perf counters.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 0,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  rs1_used_id,
    input  logic                  rs2_used_id,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  mem_read_ex,
    input  logic                  branch_taken_ex,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  if_id_flush,
    output logic                  id_ex_write_en,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_write_en,
    output logic                  mem_wb_bubble,
    output logic                  mem_error,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
    localparam int WC_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [FL_W-1:0] FL_INIT = FL_W'(FLUSH_CYCLES - 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MEM_TIMEOUT);

    hz_state_e       state_q, state_d;
    logic [FL_W-1:0] flush_left_q, flush_left_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;

    logic mem_wait;
    logic load_use;
    logic stall_inc;
    logic flush_inc;

    assign mem_wait = mem_req && !mem_ready;

    assign load_use = mem_read_ex && (rd_ex != REG_X0) &&
                      ((rs1_used_id && (rs1_id == rd_ex)) ||
                       (rs2_used_id && (rs2_id == rd_ex)));

    always_comb begin
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_write_en  = 1'b1;
        id_ex_bubble    = 1'b0;
        ex_mem_write_en = 1'b1;
        mem_wb_bubble   = 1'b0;
        state_d         = RUN;
        flush_left_d    = flush_left_q;
        wait_cnt_d      = '0;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;

        if (rst) begin
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (state_q == ERROR || mem_wait) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_ex_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
            mem_wb_bubble   = 1'b1;
            if (state_q == ERROR) begin
                state_d    = ERROR;
                wait_cnt_d = wait_cnt_q;
            end else begin
                stall_inc  = 1'b1;
                wait_cnt_d = wait_cnt_q + 1'b1;
                state_d    = (MEM_TIMEOUT > 0 && wait_cnt_d == WC_MAX)
                             ? ERROR : MEM_WAIT;
            end
        end else if (flush_left_q != '0) begin
            // Resumed or ongoing multi-cycle flush; a branch here is illegal.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_left_d = flush_left_q - 1'b1;
            state_d      = (flush_left_d != '0) ? FLUSH : RUN;
        end else if (branch_taken_ex) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
            flush_left_d = FL_INIT;
            state_d      = (FL_INIT != '0) ? FLUSH : RUN;
        end else if (load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
            stall_inc      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            flush_left_q <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign mem_error = (state_q == ERROR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .inc   (stall_inc),
        .clr   (rst),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .inc   (flush_inc),
        .clr   (rst),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two parameterisations share directed stimulus,
// checked against a priority-rule model every cycle plus literal checks.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       rs1_used_id, rs2_used_id, mem_read_ex;
    logic       branch_taken_ex, mem_req, mem_ready;

    logic        pc0, ifw0, iff0, idw0, idb0, emw0, mwb0, err0;
    logic [31:0] sc0, fc0;
    logic        pc1, ifw1, iff1, idw1, idb1, emw1, mwb1, err1;
    logic [2:0]  sc1, fc1;

    logic [6:0] ctl0, ctl1;
    assign ctl0 = {pc0, ifw0, iff0, idw0, idb0, emw0, mwb0};
    assign ctl1 = {pc1, ifw1, iff1, idw1, idb1, emw1, mwb1};

    localparam logic [6:0] C_RST    = 7'b1111111;
    localparam logic [6:0] C_NORM   = 7'b1101010;
    localparam logic [6:0] C_FREEZE = 7'b0000001;
    localparam logic [6:0] C_FLUSH  = 7'b1111110;
    localparam logic [6:0] C_STALL  = 7'b0001110;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(32)) u0 (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
        .branch_taken_ex(branch_taken_ex),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write_en(pc0), .if_id_write_en(ifw0), .if_id_flush(iff0),
        .id_ex_write_en(idw0), .id_ex_bubble(idb0),
        .ex_mem_write_en(emw0), .mem_wb_bubble(mwb0),
        .mem_error(err0), .stall_cycles(sc0), .flush_count(fc0)
    );

    hazard_unit #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(0), .CNT_W(3)) u1 (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
        .branch_taken_ex(branch_taken_ex),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write_en(pc1), .if_id_write_en(ifw1), .if_id_flush(iff1),
        .id_ex_write_en(idw1), .id_ex_bubble(idb1),
        .ex_mem_write_en(emw1), .mem_wb_bubble(mwb1),
        .mem_error(err1), .stall_cycles(sc1), .flush_count(fc1)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: per-instance pending flush cycles, consecutive waits, error, counts
    int     M_FC[2] = '{2, 3};
    int     M_MT[2] = '{4, 0};
    longint M_MX[2] = '{64'hFFFF_FFFF, 7};
    int     m_fl[2];
    int     m_wc[2];
    bit     m_er[2];
    longint m_sc[2];
    longint m_fc[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_fl[i] = 0; m_wc[i] = 0; m_er[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic [6:0] e;
                logic [6:0] act_ctl;
                logic       act_err;
                longint     act_sc, act_fc;
                bit         lu, wt;
                act_ctl = (i == 0) ? ctl0 : ctl1;
                act_err = (i == 0) ? err0 : err1;
                act_sc  = (i == 0) ? longint'(sc0) : longint'(sc1);
                act_fc  = (i == 0) ? longint'(fc0) : longint'(fc1);
                wt = mem_req && !mem_ready;
                lu = mem_read_ex && rd_ex != 0 &&
                     ((rs1_used_id && rs1_id == rd_ex) ||
                      (rs2_used_id && rs2_id == rd_ex));

                chk($sformatf("model_err%0d", i), act_err, m_er[i]);
                chk($sformatf("model_stall%0d", i), act_sc, m_sc[i]);
                chk($sformatf("model_flushcnt%0d", i), act_fc, m_fc[i]);

                if (!rst && !m_er[i] && !wt && m_fl[i] > 0 && branch_taken_ex) begin
                    errors++;
                    $display("FAIL branch_in_flush%0d: got 1 expected 0", i);
                end

                if (rst) begin
                    e = C_RST;
                    m_fl[i] = 0; m_wc[i] = 0; m_er[i] = 0;
                    m_sc[i] = 0; m_fc[i] = 0;
                end else if (m_er[i]) begin
                    e = C_FREEZE;
                end else if (wt) begin
                    e = C_FREEZE;
                    if (m_sc[i] < M_MX[i]) m_sc[i]++;
                    m_wc[i]++;
                    if (M_MT[i] > 0 && m_wc[i] >= M_MT[i]) m_er[i] = 1;
                end else begin
                    m_wc[i] = 0;
                    if (m_fl[i] > 0) begin
                        e = C_FLUSH;
                        m_fl[i]--;
                    end else if (branch_taken_ex) begin
                        e = C_FLUSH;
                        if (m_fc[i] < M_MX[i]) m_fc[i]++;
                        m_fl[i] = M_FC[i] - 1;
                    end else if (lu) begin
                        e = C_STALL;
                        if (m_sc[i] < M_MX[i]) m_sc[i]++;
                    end else begin
                        e = C_NORM;
                    end
                end
                chk($sformatf("model_ctl%0d", i), act_ctl, e);
            end
        end
    end

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_in();
        rs1_id = 0; rs2_id = 0; rd_ex = 0;
        rs1_used_id = 0; rs2_used_id = 0; mem_read_ex = 0;
        branch_taken_ex = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic set_lu();
        rd_ex = 5; mem_read_ex = 1; rs1_id = 5; rs1_used_id = 1;
    endtask

    initial begin
        rst = 1;
        idle_in();
        nx(); nx();
        mid();
        chk("rst_ctl0", ctl0, C_RST);
        chk("rst_stall0", sc0, 0);
        chk("rst_err1", err1, 0);
        nx(); rst = 0;
        mid(); chk("idle_ctl0", ctl0, C_NORM);

        // load-use on rs1
        nx(); set_lu();
        mid(); chk("lu_ctl0", ctl0, C_STALL); chk("lu_stall_pre", sc0, 0);
        nx(); idle_in();
        mid(); chk("lu_stall_post", sc0, 1); chk("lu_clear_ctl0", ctl0, C_NORM);

        // x0 destination and unused rs2 never stall
        nx(); mem_read_ex = 1; rd_ex = 0; rs1_id = 0; rs1_used_id = 1;
        mid(); chk("x0_ctl0", ctl0, C_NORM);
        nx(); rd_ex = 5; rs1_id = 3; rs2_id = 5; rs2_used_id = 0;
        mid(); chk("rs2_unused_ctl0", ctl0, C_NORM);
        nx(); idle_in();

        // taken branch with concurrent load-use
        nx(); set_lu(); branch_taken_ex = 1;
        mid(); chk("br_ctl0", ctl0, C_FLUSH);
        nx(); branch_taken_ex = 0;
        mid(); chk("br2_ctl0", ctl0, C_FLUSH); chk("br_fc0", fc0, 1);
        nx(); idle_in();
        mid();
        chk("br3_ctl0", ctl0, C_NORM);
        chk("br3_ctl1", ctl1, C_FLUSH);
        chk("br_stall0", sc0, 1);
        nx(); nx();

        // three-cycle memory wait then ready
        mem_req = 1; mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            mid(); chk("mw_ctl0", ctl0, C_FREEZE);
            nx();
        end
        mem_ready = 1;
        mid(); chk("mw_done_ctl0", ctl0, C_NORM);
        nx(); idle_in();
        mid(); chk("mw_stall0", sc0, 4); chk("mw_err0", err0, 0);

        // timeout on u0, unbounded wait on u1
        nx(); mem_req = 1; mem_ready = 0;
        for (int k = 0; k < 4; k++) begin
            mid(); nx();
        end
        mid(); chk("to_err0", err0, 1); chk("to_ctl0", ctl0, C_FREEZE);
        for (int k = 0; k < 20; k++) nx();
        mem_ready = 1;
        mid();
        chk("err_hold_ctl0", ctl0, C_FREEZE);
        chk("err_stall0", sc0, 8);
        chk("sat_stall1", sc1, 7);
        chk("noto_err1", err1, 0);
        chk("ready_ctl1", ctl1, C_NORM);
        nx(); rst = 1; idle_in();
        mid(); chk("rst2_ctl0", ctl0, C_RST);
        nx(); rst = 0;
        mid();
        chk("rst2_err0", err0, 0);
        chk("rst2_stall0", sc0, 0);
        chk("rst2_ctl0n", ctl0, C_NORM);

        // flush interrupted by memory wait (u1 has 3 flush cycles)
        nx(); branch_taken_ex = 1;
        mid(); chk("fw1_ctl1", ctl1, C_FLUSH);
        nx(); branch_taken_ex = 0; mem_req = 1; mem_ready = 0;
        mid(); chk("fw2_ctl1", ctl1, C_FREEZE);
        nx();
        mid(); chk("fw3_ctl1", ctl1, C_FREEZE);
        nx(); mem_ready = 1;
        mid(); chk("fw4_ctl1", ctl1, C_FLUSH); chk("fw4_ctl0", ctl0, C_FLUSH);
        nx(); idle_in();
        mid(); chk("fw5_ctl1", ctl1, C_FLUSH); chk("fw5_ctl0", ctl0, C_NORM);
        nx();
        mid(); chk("fw6_ctl1", ctl1, C_NORM); chk("fw_fc1", fc1, 1);
        nx(); nx();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Stall/flush controller for the 5-stage pipeline; the producer-side counterpart of operand forwarding.
- Decides when the pipeline cannot forward: load-use in ID, taken branch resolved in EX, multi-cycle data-memory access in MEM.
- Drives the per-stage write-enables and bubble/flush controls.
- Keeps saturating stall and flush counters for performance analysis.

Parameters:
FLUSH_CYCLES, 1, cycles IF/ID and ID/EX are flushed per taken branch (>=1)
MEM_TIMEOUT, 0, max consecutive memory-wait cycles before error; 0 disables timeout
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
rs1_id  in  5  source register 1 of instruction in ID
rs2_id  in  5  source register 2 of instruction in ID
rs1_used_id  in  1  ID instruction reads rs1
rs2_used_id  in  1  ID instruction reads rs2
rd_ex  in  5  destination register of instruction in EX
mem_read_ex  in  1  EX instruction is a load
branch_taken_ex  in  1  branch/jump in EX resolved taken (PC redirect)
mem_req  in  1  MEM stage has a valid data-memory access
mem_ready  in  1  data memory completes access this cycle
pc_write_en  out  1  PC register update enable
if_id_write_en  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_write_en  out  1  ID/EX register enable
id_ex_bubble  out  1  ID/EX loads NOP
ex_mem_write_en  out  1  EX/MEM register enable
mem_wb_bubble  out  1  MEM/WB loads NOP
mem_error  out  1  sticky memory timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with pc_write_en=0 (excluding ERROR)
flush_count  out  CNT_W  saturating count of accepted taken branches

Behaviour:
Interface:
- One clock, clk.
- Reset rst is synchronous and active-high.
- Control outputs are Mealy (combinational from state + inputs); counters and mem_error are registered.

Reset:
- While rst=1: state=RUN, flush_left=0, wait_cnt=0, counters=0, mem_error=0.
- Control outputs while rst=1: all write enables=1, if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1 (pipeline fills with NOPs).
- Reset mid-operation aborts any wait/flush/error immediately.

Default (no event): all enables=1, flush/bubble=0.

Event priority, highest first:
1. ERROR state.
2. Memory wait.
3. Flush: taken branch, or FLUSH state.
4. Load-use.

Memory wait (mem_req=1 & mem_ready=0):
- Freeze: pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en = 0; mem_wb_bubble=1.
- All other events are ignored that cycle; a taken branch is re-presented later because EX is frozen.
- Cycle with mem_ready=1 proceeds normally.

Taken branch (not frozen):
- if_id_flush=1, id_ex_bubble=1, pc_write_en=1 (target loads).
- Any concurrent load-use is suppressed, since the ID instruction is wrong-path.
- flush_count+1.
- If FLUSH_CYCLES>1: flush_left=FLUSH_CYCLES-1, go to FLUSH.

FLUSH state:
- Asserts if_id_flush=1, id_ex_bubble=1, pc_write_en=1.
- flush_left decrements; return to RUN when it reaches 0.
- A memory wait in FLUSH holds flush_left and resumes flushing afterwards.
- branch_taken_ex in FLUSH cannot legally occur; it is ignored and flagged by a bench assertion.

Load-use:
- Condition: mem_read_ex=1, rd_ex!=0, and ((rs1_used_id & rs1_id==rd_ex) or (rs2_used_id & rs2_id==rd_ex)).
- Response: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1 for exactly that cycle.
- The bubble clears the hazard next cycle.

States: RUN, FLUSH, MEM_WAIT, ERROR.
- MEM_WAIT is entered after the first freeze cycle.
- wait_cnt counts consecutive freeze cycles; the first freeze cycle counts as 1.
- If MEM_TIMEOUT>0 and wait_cnt reaches MEM_TIMEOUT with mem_ready still 0: go to ERROR next cycle and set mem_error=1.
- On mem_ready: return to FLUSH if flush_left>0, else RUN; wait_cnt=0.
- ERROR: freeze outputs held permanently, counters frozen; exit only via rst.

Counters:
- Both counters saturate at all-ones and never wrap.
- stall_cycles increments on load-use and memory-wait cycles.

Decomposition:
pipeline_pkg holds:
- hazard state enum (RUN, FLUSH, MEM_WAIT, ERROR)
- REG_ADDR_W=5
- REG_X0=5'd0
- NOP encoding used by stage registers

Sub-module sat_counter (parameter W; inputs inc, clr; output count), instantiated twice.

Test Plan:
1. rd_ex=5, mem_read_ex=1, rs1_id=5, rs1_used_id=1 -> one cycle pc_write_en=0, if_id_write_en=0, id_ex_bubble=1; stall_cycles 0->1.
2. rd_ex=0, mem_read_ex=1, rs1_id=0 used; separately rs2_id=5 with rs2_used_id=0 -> no stall, all enables 1.
3. FLUSH_CYCLES=2: branch_taken_ex=1 together with a load-use hazard -> if_id_flush=id_ex_bubble=1 for 2 cycles, pc_write_en=1 throughout, flush_count=1, stall_cycles unchanged.
4. mem_req=1 with mem_ready=0 for 3 cycles then 1 -> 3 freeze cycles (ex_mem_write_en=0, mem_wb_bubble=1), normal on 4th; stall_cycles+3, mem_error=0.
5. MEM_TIMEOUT=4, mem_ready stuck 0 -> mem_error=1 after 4th wait cycle, freeze persists 20 cycles; rst pulse -> counters 0, mem_error=0, state RUN.
6. FLUSH_CYCLES=3: taken branch, then 2 memory-wait cycles -> flush, freeze, freeze, flush, flush (3 flush cycles total); flush_count=1.
